axi_ram_responder: RTL
======================

# axi_ram_responder

AXI4 responder (slave) that answers bursts issued by the CPU-side master after the `axi_cdc_intf` crossing. It serves them from an on-chip byte-writable RAM. The block sits on the `m0` clock domain as a boot/scratch memory target behind the SoC crossbar. It handles one transaction at a time, alternates priority between reads and writes, and supports FIXED/INCR bursts (WRAP optionally) of up to 256 beats.

## Interface
- `MEM_BYTES`, 4096: RAM size in bytes; power of two, ≥ 64; byte offset = `addr[$clog2(MEM_BYTES)-1:0]`, upper bits ignored.
- `AXI_ID_WIDTH`, 4: ID width of the bus.
- `aclk` input 1: the only clock; all logic on rising edge.
- `aresetn` input 1: asynchronous, active-low reset.
- `s0` `AXI_BUS.Slave` (ADDR 32, DATA 32, ID `AXI_ID_WIDTH`): full AXI4 channel set. `aw_lock`/`cache`/`prot`/`qos`/`region`/`user` ignored; `r_user`/`b_user` driven 0.

## Operation
- FSM states: `IDLE`, `READ`, `WDATA`, `WRESP`.
- `IDLE` arbitration:
  - AR only → `READ`; AW only → `WDATA`.
  - Both valid → grant the channel not served last (`last_was_read` flag); after reset, read wins.
  - `ar_ready` = `IDLE` && read granted; `aw_ready` = `IDLE` && write granted (combinational from state, valids, flag).
- Handshake captures `id`, `addr`, `len` (8 bit), `size`, `burst`, and clears the beat counter `cnt` to 0.
- Error check at capture: `size > 2`, or `burst` == 2'b11, or WRAP with `len` ∉ {1,3,7,15} → transaction flagged SLVERR.
- SLVERR reads return `r_data` = 0 on every beat. SLVERR writes consume all beats but modify no memory.
- `READ`:
  - `r_valid` = 1, `r_data` = word at current address (bits [1:0] dropped), `r_id` = captured id.
  - `r_resp` = OKAY or SLVERR; `r_last` = (`cnt` == `len`).
  - On `r_valid && r_ready`: advance address and `cnt`; if last → `IDLE`, set `last_was_read` = 1.
- `WDATA`:
  - `w_ready` = 1; on `w_valid && w_ready`, write bytes where `w_strb[i]` = 1, then advance address and `cnt`.
  - `w_last` mismatch (asserted when `cnt` != `len`, or missing when `cnt` == `len`) sets a sticky SLVERR. The burst still ends after exactly `len`+1 beats.
  - After the last beat → `WRESP`.
- `WRESP`: `b_valid` = 1, `b_id`, `b_resp`; on `b_ready` → `IDLE`, set `last_was_read` = 0.
- Address advance:
  - FIXED: address unchanged.
  - INCR: address += `1<<size`, wrapping modulo `MEM_BYTES`.
  - WRAP: see Configuration.
  - Increments are based on the size-aligned address; the first beat uses the unaligned address as given.

## Timing
- Reset values: all `*_ready`, `r_valid`, `b_valid` = 0; `r_data`, `r_resp`, `r_id`, `b_resp`, `b_id`, `r_last` = 0; state `IDLE`; `last_was_read` = 0. RAM contents are not reset.
- AR handshake at cycle T → first R beat valid at T+1. Sustained rate is 1 beat/cycle while `r_ready` = 1. Outputs hold stable while `r_valid && !r_ready`.
- AW handshake at T → `w_ready` from T+1. Last W beat at U → `b_valid` at U+1.
- A write beat at cycle U is visible to a read beat issued at U+1 or later.
- `ar_ready`/`aw_ready` are never high outside `IDLE`. A new AR/AW is accepted no earlier than the cycle after R last/B handshake.
- W beats presented before the AW handshake are not accepted (`w_ready` = 0).
- `aresetn` deasserted mid-burst: immediate return to `IDLE`, no pending response emitted; any RAM bytes already written stay written.

## Configuration
- `AXI_RAM_RESPONDER_WRAP_EN` defined: WRAP bursts supported. Boundary = `(len+1)<<size` aligned; address wraps to the boundary base after reaching base+boundary.
- Macro undefined: any WRAP burst is flagged SLVERR (full beat count, zero read data, no writes). The wrap logic is not built.

## Structure
- `axi_pkg` (existing) provides the burst encodings (FIXED/INCR/WRAP) and the response codes (OKAY/SLVERR). No new package constants are needed.
- The FSM state enum is local to the module.
- Sub-module `axi_ram_addr_gen`: combinational next-address computation from (addr, size, len, burst); it holds the macro-guarded wrap logic.
- RAM is a `logic [3:0][7:0] mem [MEM_BYTES/4]` array with per-byte write enable.

## Test plan
- INCR write: len=3, size=2, addr 0x100, data 0x11111111..0x44444444, strb 4'hF; then INCR read of the same → four beats match, `r_last` only on beat 4, both resp OKAY, `b_valid` 1 cycle after last W.
- Byte strobes: write 0xAABBCCDD with strb 4'b0101 to a zeroed word, then read → 0x00BB00DD.
- AR and AW both valid in `IDLE` right after reset → read granted first; next simultaneous request grants the write; `r_id`/`b_id` echo ids 0x3/0x5.
- `r_ready` held low 3 cycles mid-burst → `r_data`/`r_last` stable, no beat skipped.
- Error cases: `size`=3 read → SLVERR, data 0 each beat. Write len=1 with `w_last` on beat 0 → 2 beats accepted, `b_resp` SLVERR.
- WRAP len=3, size=2, addr 0x1C: with macro → beats at 0x1C, 0x10, 0x14, 0x18; without macro → SLVERR. Separately, assert `aresetn` low mid-read → all valids 0 next edge, `ar_ready` high after release.

Source files
------------

// File: rtl/axi_ram_responder_pkg.sv
// AXI encodings and the capture-time legality check shared by axi_ram_responder and its
// address generator.
package axi_ram_responder_pkg;

  typedef enum logic [1:0] {
    BurstFixed = 2'b00,
    BurstIncr  = 2'b01,
    BurstWrap  = 2'b10,
    BurstRsvd  = 2'b11
  } burst_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // True when a burst must be answered with SLVERR at address capture.
  function automatic logic txn_illegal(logic [2:0] size, logic [7:0] len, logic [1:0] burst,
                                       logic wrap_en);
    logic bad_wrap_len;
    bad_wrap_len = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
    return (size > 3'd2) || (burst == BurstRsvd) ||
           ((burst == BurstWrap) && (!wrap_en || bad_wrap_len));
  endfunction

endpackage

// File: rtl/axi_ram_addr_gen.sv
// Combinational next-beat address for FIXED/INCR bursts; WRAP is built only when
// AXI_RAM_RESPONDER_WRAP_EN is defined.
module axi_ram_addr_gen
  import axi_ram_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = 12
) (
  input  logic [AddrWidth-1:0] addr,
  input  logic [2:0]           size,
  input  logic [7:0]           len,
  input  logic [1:0]           burst,
  output logic [AddrWidth-1:0] next_addr
);

  logic [AddrWidth-1:0] step;
  logic [AddrWidth-1:0] aligned;
  logic [AddrWidth-1:0] incr;

  assign step    = AddrWidth'(1) << size;
  assign aligned = addr & ~(step - AddrWidth'(1));
  assign incr    = aligned + step;

`ifdef AXI_RAM_RESPONDER_WRAP_EN
  logic [AddrWidth-1:0] wrap_mask;
  // Legal WRAP lengths make (len+1)<<size a power of two, so a mask selects the window.
  assign wrap_mask = ((AddrWidth'(len) + AddrWidth'(1)) << size) - AddrWidth'(1);
`else
  logic unused_len;
  assign unused_len = ^len;
`endif

  always_comb begin
    next_addr = addr;
    case (burst)
      BurstIncr: next_addr = incr;
`ifdef AXI_RAM_RESPONDER_WRAP_EN
      BurstWrap: next_addr = (aligned & ~wrap_mask) | (incr & wrap_mask);
`endif
      default:   next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 responder serving one burst at a time from a byte-writable RAM, alternating read/write
// priority. Define AXI_RAM_RESPONDER_WRAP_EN to accept WRAP bursts (otherwise SLVERR).
module axi_ram_responder
  import axi_ram_responder_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 4096,
  parameter int unsigned AXI_ID_WIDTH = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [AXI_ID_WIDTH-1:0] aw_id,
  input  logic [31:0]             aw_addr,
  input  logic [7:0]              aw_len,
  input  logic [2:0]              aw_size,
  input  logic [1:0]              aw_burst,
  input  logic                    aw_lock,
  input  logic [3:0]              aw_cache,
  input  logic [2:0]              aw_prot,
  input  logic [3:0]              aw_qos,
  input  logic [3:0]              aw_region,
  input  logic                    aw_user,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [31:0]             w_data,
  input  logic [3:0]              w_strb,
  input  logic                    w_last,
  input  logic                    w_user,
  input  logic                    w_valid,
  output logic                    w_ready,
  output logic [AXI_ID_WIDTH-1:0] b_id,
  output logic [1:0]              b_resp,
  output logic                    b_user,
  output logic                    b_valid,
  input  logic                    b_ready,
  input  logic [AXI_ID_WIDTH-1:0] ar_id,
  input  logic [31:0]             ar_addr,
  input  logic [7:0]              ar_len,
  input  logic [2:0]              ar_size,
  input  logic [1:0]              ar_burst,
  input  logic                    ar_lock,
  input  logic [3:0]              ar_cache,
  input  logic [2:0]              ar_prot,
  input  logic [3:0]              ar_qos,
  input  logic [3:0]              ar_region,
  input  logic                    ar_user,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  output logic [AXI_ID_WIDTH-1:0] r_id,
  output logic [31:0]             r_data,
  output logic [1:0]              r_resp,
  output logic                    r_last,
  output logic                    r_user,
  output logic                    r_valid,
  input  logic                    r_ready
);

  localparam int unsigned AddrWidth = $clog2(MEM_BYTES);
`ifdef AXI_RAM_RESPONDER_WRAP_EN
  localparam logic WrapEn = 1'b1;
`else
  localparam logic WrapEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRead, StWdata, StWresp} state_e;

  state_e                  state_q, state_d;
  logic                    last_was_read_q, last_was_read_d;
  logic [AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    wlast_err_q, wlast_err_d;

  logic [3:0][7:0]      mem [MEM_BYTES/4];
  logic [3:0]           mem_we;
  logic [AddrWidth-1:0] next_addr;
  logic                 grant_read, grant_write, beat_last;

  logic unused_sideband;
  assign unused_sideband = ^{aw_addr[31:AddrWidth], aw_lock, aw_cache, aw_prot, aw_qos,
                             aw_region, aw_user, w_user, ar_addr[31:AddrWidth], ar_lock,
                             ar_cache, ar_prot, ar_qos, ar_region, ar_user};

  assign r_user = 1'b0;
  assign b_user = 1'b0;

  // With both channels pending, serve the one not served last.
  assign grant_read  = ar_valid && (!aw_valid || !last_was_read_q);
  assign grant_write = aw_valid && !grant_read;
  assign beat_last   = (cnt_q == len_q);

  axi_ram_addr_gen #(
    .AddrWidth(AddrWidth)
  ) u_addr_gen (
    .addr     (addr_q),
    .size     (size_q),
    .len      (len_q),
    .burst    (burst_q),
    .next_addr(next_addr)
  );

  always_comb begin
    state_d         = state_q;
    last_was_read_d = last_was_read_q;
    id_d            = id_q;
    addr_d          = addr_q;
    len_d           = len_q;
    size_d          = size_q;
    burst_d         = burst_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    wlast_err_d     = wlast_err_q;
    ar_ready        = 1'b0;
    aw_ready        = 1'b0;
    w_ready         = 1'b0;
    r_valid         = 1'b0;
    r_data          = '0;
    r_id            = '0;
    r_resp          = RespOkay;
    r_last          = 1'b0;
    b_valid         = 1'b0;
    b_id            = '0;
    b_resp          = RespOkay;
    mem_we          = '0;

    unique case (state_q)
      StIdle: begin
        ar_ready = grant_read;
        aw_ready = grant_write;
        if (grant_read) begin
          id_d        = ar_id;
          addr_d      = ar_addr[AddrWidth-1:0];
          len_d       = ar_len;
          size_d      = ar_size;
          burst_d     = ar_burst;
          cnt_d       = '0;
          err_d       = txn_illegal(ar_size, ar_len, ar_burst, WrapEn);
          wlast_err_d = 1'b0;
          state_d     = StRead;
        end else if (grant_write) begin
          id_d        = aw_id;
          addr_d      = aw_addr[AddrWidth-1:0];
          len_d       = aw_len;
          size_d      = aw_size;
          burst_d     = aw_burst;
          cnt_d       = '0;
          err_d       = txn_illegal(aw_size, aw_len, aw_burst, WrapEn);
          wlast_err_d = 1'b0;
          state_d     = StWdata;
        end
      end
      StRead: begin
        r_valid = 1'b1;
        r_id    = id_q;
        r_resp  = err_q ? RespSlverr : RespOkay;
        r_last  = beat_last;
        r_data  = err_q ? '0 : mem[addr_q[AddrWidth-1:2]];
        if (r_ready) begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          if (beat_last) begin
            state_d         = StIdle;
            last_was_read_d = 1'b1;
          end
        end
      end
      StWdata: begin
        w_ready = 1'b1;
        if (w_valid) begin
          mem_we = err_q ? 4'b0000 : w_strb;
          // The beat count alone ends the burst; a misplaced w_last only taints the response.
          if (w_last != beat_last) wlast_err_d = 1'b1;
          addr_d = next_addr;
          cnt_d  = cnt_q + 8'd1;
          if (beat_last) state_d = StWresp;
        end
      end
      StWresp: begin
        b_valid = 1'b1;
        b_id    = id_q;
        b_resp  = (err_q || wlast_err_q) ? RespSlverr : RespOkay;
        if (b_ready) begin
          state_d         = StIdle;
          last_was_read_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= StIdle;
      last_was_read_q <= 1'b0;
      id_q            <= '0;
      addr_q          <= '0;
      len_q           <= '0;
      size_q          <= '0;
      burst_q         <= '0;
      cnt_q           <= '0;
      err_q           <= 1'b0;
      wlast_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_was_read_q <= last_was_read_d;
      id_q            <= id_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      size_q          <= size_d;
      burst_q         <= burst_d;
      cnt_q           <= cnt_d;
      err_q           <= err_d;
      wlast_err_q     <= wlast_err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) mem[addr_q[AddrWidth-1:2]][i] <= w_data[8*i +: 8];
    end
  end

endmodule
